// File: rtl/player_sprite_plotter.sv
// Draws the player sprite on the VGA adapter write port. When the player moves, the
// old box is erased with the background colour and the new box is then drawn.
module player_sprite_plotter #(
  parameter int unsigned SPRITE_W  = 4,
  parameter int unsigned SPRITE_H  = 4,
  parameter int unsigned SCREEN_W  = 160,
  parameter int unsigned SCREEN_H  = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] playerx,
  input  logic [6:0] playery,
  input  logic [2:0] colour,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2
  } state_t;

  localparam logic [3:0] DX_LAST = 4'(SPRITE_W - 1);
  localparam logic [3:0] DY_LAST = 4'(SPRITE_H - 1);
  localparam logic [8:0] X_LIMIT = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIMIT = 8'(SCREEN_H);

  state_t     state_q, state_d;
  logic [7:0] old_x_q, old_x_d, new_x_q, new_x_d;
  logic [6:0] old_y_q, old_y_d, new_y_q, new_y_d;
  logic [2:0] new_col_q, new_col_d;
  logic       first_draw_q, first_draw_d;
  logic [3:0] dx_q, dx_d, dy_q, dy_d;

  logic [7:0] vga_x_q, vga_x_d;
  logic [6:0] vga_y_q, vga_y_d;
  logic [2:0] vga_colour_q, vga_colour_d;
  logic       vga_plot_q, vga_plot_d;
  logic       busy_q, busy_d;

  logic       last_px;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;

  // Next-state logic: scan counters and box bookkeeping.
  always_comb begin
    state_d      = state_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_col_d    = new_col_q;
    first_draw_d = first_draw_q;
    dx_d         = dx_q;
    dy_d         = dy_q;
    last_px      = (dx_q == DX_LAST) && (dy_q == DY_LAST);

    case (state_q)
      IDLE: begin
        if (first_draw_q || ({playerx, playery} != {old_x_q, old_y_q})) begin
          new_x_d   = playerx;
          new_y_d   = playery;
          new_col_d = colour;
          dx_d      = 4'd0;
          dy_d      = 4'd0;
          state_d   = first_draw_q ? DRAW : ERASE;
        end
      end
      ERASE, DRAW: begin
        if (dx_q == DX_LAST) begin
          dx_d = 4'd0;
          dy_d = dy_q + 4'd1;
        end else begin
          dx_d = dx_q + 4'd1;
        end
        if (last_px) begin
          dx_d = 4'd0;
          dy_d = 4'd0;
          if (state_q == ERASE) begin
            state_d = DRAW;
          end else begin
            old_x_d      = new_x_q;
            old_y_d      = new_y_q;
            first_draw_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the first pixel of a box appears
  // in the cycle right after the move is detected. Sums are one bit wider so
  // off-screen pixels are clipped rather than wrapped.
  always_comb begin
    base_x       = (state_d == ERASE) ? old_x_q : new_x_d;
    base_y       = (state_d == ERASE) ? old_y_q : new_y_d;
    sum_x        = {1'b0, base_x} + {5'b0, dx_d};
    sum_y        = {1'b0, base_y} + {4'b0, dy_d};
    vga_x_d      = sum_x[7:0];
    vga_y_d      = sum_y[6:0];
    vga_colour_d = (state_d == ERASE) ? BG_COLOUR : new_col_d;
    busy_d       = (state_d != IDLE);
    vga_plot_d   = busy_d && (sum_x < X_LIMIT) && (sum_y < Y_LIMIT);
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      old_x_q      <= 8'd0;
      old_y_q      <= 7'd0;
      new_x_q      <= 8'd0;
      new_y_q      <= 7'd0;
      new_col_q    <= 3'd0;
      first_draw_q <= 1'b1;
      dx_q         <= 4'd0;
      dy_q         <= 4'd0;
      vga_x_q      <= 8'd0;
      vga_y_q      <= 7'd0;
      vga_colour_q <= 3'd0;
      vga_plot_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_col_q    <= new_col_d;
      first_draw_q <= first_draw_d;
      dx_q         <= dx_d;
      dy_q         <= dy_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      busy_q       <= busy_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_player_sprite_plotter.sv
// Scoreboard bench for player_sprite_plotter: directed moves push expected pixels and
// busy-run lengths; a negedge monitor pops and compares whatever the DUT emits.
module tb_player_sprite_plotter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] px = 8'd0;
  logic [6:0] py = 7'd0;
  logic [2:0] col = 3'd0;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic       busy;

  logic [17:0] exp_q[$];
  logic [7:0]  bexp_q[$];
  int errors = 0;
  int checks = 0;
  int run_len = 0;
  int gap = 0;
  int last_gap = 0;

  player_sprite_plotter dut (
    .CLOCK_50  (clk),
    .reset     (rst),
    .playerx   (px),
    .playery   (py),
    .colour    (col),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Monitor: pixel scoreboard and busy-run length checks.
  always @(negedge clk) begin
    logic [17:0] e;
    logic [7:0]  b;
    if (vga_plot) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_plot got x=%0d y=%0d c=%b required no plot",
                 vga_x, vga_y, vga_colour);
      end else begin
        e = exp_q.pop_front();
        if ({vga_x, vga_y, vga_colour} !== e || !busy) begin
          errors++;
          $display("FAIL pixel got x=%0d y=%0d c=%b busy=%b required x=%0d y=%0d c=%b busy=1",
                   vga_x, vga_y, vga_colour, busy, e[17:10], e[9:3], e[2:0]);
        end
      end
    end
    if (busy === 1'b1) begin
      if (run_len == 0) begin
        last_gap = gap;
      end
      gap = 0;
      run_len++;
    end else begin
      gap++;
      if (run_len != 0) begin
        checks++;
        if (bexp_q.size() == 0) begin
          errors++;
          $display("FAIL busy_run got len=%0d required no busy", run_len);
        end else begin
          b = bexp_q.pop_front();
          if (run_len != int'(b)) begin
            errors++;
            $display("FAIL busy_run got len=%0d required %0d", run_len, b);
          end
        end
        run_len = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input int x, input int y, input logic [2:0] c);
    exp_q.push_back({8'(x), 7'(y), c});
  endtask

  task automatic push_box(input int bx, input int by, input logic [2:0] c);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 4; i++)
        push_px(bx + i, by + j, c);
  endtask

  task automatic check_zero(input string tag);
    checks++;
    if ({vga_x, vga_y, vga_colour, vga_plot, busy} !== 20'd0) begin
      errors++;
      $display("FAIL %s got x=%0d y=%0d c=%b plot=%b busy=%b required all 0",
               tag, vga_x, vga_y, vga_colour, vga_plot, busy);
    end
  endtask

  task automatic wait_drain(input int max_cyc, input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bexp_q.size() != 0) && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || bexp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout pixels_left=%0d runs_left=%0d required 0",
               tag, exp_q.size(), bexp_q.size());
      exp_q.delete();
      bexp_q.delete();
    end
    tick();
  endtask

  initial begin
    int busy_seen;

    // First draw after reset: draw only, no erase.
    px = 8'd10; py = 7'd20; col = 3'b100;
    repeat (3) tick();
    check_zero("reset_outputs");
    push_box(10, 20, 3'b100);
    bexp_q.push_back(8'd16);
    rst = 1'b0;
    wait_drain(200, "first_draw");

    // One-pixel move right: erase old box then draw new one.
    push_box(10, 20, 3'b000);
    push_box(11, 20, 3'b100);
    bexp_q.push_back(8'd32);
    px = 8'd11;
    wait_drain(200, "move_right");

    // Static position: nothing plotted, never busy.
    busy_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (busy) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL hold_idle got busy_cycles=%0d required 0", busy_seen);
    end

    // Bottom-right corner: only 4 on-screen pixels.
    push_box(11, 20, 3'b000);
    push_px(158, 118, 3'b010);
    push_px(159, 118, 3'b010);
    push_px(158, 119, 3'b010);
    push_px(159, 119, 3'b010);
    bexp_q.push_back(8'd32);
    px = 8'd158; py = 7'd118; col = 3'b010;
    wait_drain(200, "corner_clip");

    // Move to (30,30), then change to (50,50) during DRAW.
    push_px(158, 118, 3'b000);
    push_px(159, 118, 3'b000);
    push_px(158, 119, 3'b000);
    push_px(159, 119, 3'b000);
    push_box(30, 30, 3'b001);
    bexp_q.push_back(8'd32);
    push_box(30, 30, 3'b000);
    push_box(50, 50, 3'b001);
    bexp_q.push_back(8'd32);
    px = 8'd30; py = 7'd30; col = 3'b001;
    repeat (21) tick();
    px = 8'd50; py = 7'd50;
    wait_drain(300, "mid_draw_change");
    checks++;
    if (last_gap != 1) begin
      errors++;
      $display("FAIL idle_gap got %0d required 1", last_gap);
    end

    // Reset in cycle 8 of ERASE: 7 erase pixels seen, then draw-only at new spot.
    push_box(50, 50, 3'b000);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    bexp_q.push_back(8'd7);
    px = 8'd70; py = 7'd40; col = 3'b110;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    check_zero("reset_mid_erase");
    repeat (2) tick();
    check_zero("reset_held");
    checks++;
    if (exp_q.size() != 0 || bexp_q.size() != 0) begin
      errors++;
      $display("FAIL erase_before_reset got pixels_left=%0d runs_left=%0d required 0",
               exp_q.size(), bexp_q.size());
      exp_q.delete();
      bexp_q.delete();
    end
    push_box(70, 40, 3'b110);
    bexp_q.push_back(8'd16);
    rst = 1'b0;
    wait_drain(200, "redraw_after_reset");

    repeat (5) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/player_sprite_plotter.md
Name: player_sprite_plotter

Overview:
- Consumer side of the player-position interface: takes the 8-bit x / 7-bit y player position produced by the movement logic and draws the player onto the 160x120 VGA adapter.
- When the position changes, it erases the old SPRITE_W x SPRITE_H box with background colour, then draws the new box with the player colour.
- It emits one pixel per clock on the adapter's x/y/colour/plot write port.
- Sits between the movement block and the VGA adapter.

Parameters:
SPRITE_W, 4, sprite width in pixels (1..16)
SPRITE_H, 4, sprite height in pixels (1..16)
SCREEN_W, 160, visible width; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible height; pixels with y >= SCREEN_H are clipped
BG_COLOUR, 3'b000, colour used when erasing

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset
playerx  input  8  player top-left x, synchronous to CLOCK_50
playery  input  7  player top-left y, synchronous to CLOCK_50
colour  input  3  player colour, sampled together with position
vga_x  output  8  pixel x to adapter
vga_y  output  7  pixel y to adapter
vga_colour  output  3  pixel colour to adapter
vga_plot  output  1  write strobe; adapter writes pixel when high
busy  output  1  high while erasing or drawing

Behaviour:
- Reset (async, any time, including mid-operation):
  - vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0.
  - State=IDLE; old_x/old_y=0; first_draw=1.
  - Reset mid-operation discards the box in progress; nothing is erased after reset.
- States are IDLE, ERASE and DRAW. All outputs are registered.
- IDLE: vga_plot=0, busy=0. On each edge, the block acts if first_draw=1 OR {playerx,playery} != {old_x,old_y}:
  - Latch new_x=playerx, new_y=playery, new_col=colour.
  - Clear dx and dy to 0.
  - Go to ERASE if first_draw=0, else go to DRAW.
  - Otherwise stay in IDLE.
- Inputs are ignored outside IDLE. Changes during ERASE/DRAW are picked up on return to IDLE, by comparison against the box just drawn.
- ERASE: one pixel per cycle, busy=1.
  - Outputs: vga_x=old_x+dx, vga_y=old_y+dy, vga_colour=BG_COLOUR.
  - Scan is row-major: dx increments first and wraps to 0 at SPRITE_W-1, then dy increments.
  - After pixel (SPRITE_W-1, SPRITE_H-1), clear dx/dy and go to DRAW.
- DRAW: same scan at new_x/new_y with vga_colour=new_col.
  - After the last pixel: old_x<=new_x, old_y<=new_y, first_draw<=0, go to IDLE.
- Timing:
  - The first pixel is on the outputs in the cycle after the IDLE detection edge.
  - ERASE occupies exactly SPRITE_W*SPRITE_H cycles; DRAW occupies exactly SPRITE_W*SPRITE_H cycles.
  - A move costs 2*SPRITE_W*SPRITE_H busy cycles; the first draw costs SPRITE_W*SPRITE_H.
  - busy drops in the same cycle vga_plot returns to 0.
  - Back-to-back changes are handled with at least 1 IDLE cycle between boxes.
- Arithmetic and clipping:
  - Coordinates are computed 9 bits wide (x) and 8 bits wide (y), with no wrap.
  - If the sum is >= SCREEN_W or >= SCREEN_H, that cycle still elapses with vga_plot=0.
  - vga_x/vga_y carry the truncated low bits; their value is don't-care when vga_plot=0.
  - Clipping never shortens the scan.
- playerx/playery values themselves are never rejected; off-screen boxes are clipped pixel by pixel.

Test Plan:
- Reset with playerx=10, playery=20, colour=3'b100:
  - 16 cycles of vga_plot=1 covering x 10..13, y 20..23, row-major, colour 3'b100.
  - No erase pixels; busy high for exactly 16 cycles, then IDLE with plot=0.
- From (10,20), set playerx=11:
  - 16 erase pixels at x 10..13, y 20..23 with colour 000.
  - Then 16 draw pixels at x 11..14, y 20..23.
  - 32 contiguous busy cycles, then IDLE.
- Position held constant for 1000 cycles after drawing: vga_plot never asserts, busy stays 0.
- Draw at (158,118):
  - Exactly 4 plotted pixels: (158,118), (159,118), (158,119), (159,119).
  - The other 12 scan cycles have plot=0; DRAW still lasts 16 cycles.
- Change position to (50,50) in cycle 5 of a DRAW to (30,30), then hold:
  - The (30,30) box completes unaltered.
  - After 1 IDLE cycle, the (30,30) box is erased and (50,50) is drawn.
- Assert reset in cycle 8 of an ERASE:
  - All outputs 0 immediately (asynchronously).
  - After release, a draw-only sequence of 16 pixels at the current position, with no erase.
